// File: rtl/spi_xfer_arbiter.sv
// Round-robin arbiter that shares one spi_master between NREQ requesters.
// It holds one transfer in flight and ends it on spi_done or on a timeout.
module spi_xfer_arbiter #(
  parameter int NREQ    = 4,
  parameter int DW      = 12,
  parameter int TIMEOUT = 1023,
  parameter int GAP     = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      req_data,
  output logic [NREQ-1:0]         grant,
  output logic [NREQ-1:0]         cmpl,
  output logic                    timeout_err,
  output logic                    busy,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    newd,
  output logic [DW-1:0]           din,
  input  logic                    spi_done
);

  localparam int OW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam int GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_GAP
  } state_t;

  state_t          state_q, state_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [NREQ-1:0] cmpl_q, cmpl_d;
  logic            timeout_err_q, timeout_err_d;
  logic            busy_q, busy_d;
  logic [OW-1:0]   owner_q, owner_d;
  logic [OW-1:0]   last_q, last_d;
  logic            newd_q, newd_d;
  logic [DW-1:0]   din_q, din_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;

  logic            sel_found;
  logic [OW-1:0]   sel_idx;

  // Scan starting just after the last winner so every requester gets a turn.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!sel_found && req[(int'(last_q) + k) % NREQ]) begin
        sel_found = 1'b1;
        sel_idx   = OW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = '0;
    cmpl_d        = '0;
    timeout_err_d = 1'b0;
    newd_d        = 1'b0;
    busy_d        = busy_q;
    owner_d       = owner_q;
    last_d        = last_q;
    din_d         = din_q;
    cnt_d         = cnt_q;
    gcnt_d        = gcnt_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (sel_found) begin
          grant_d[sel_idx] = 1'b1;
          newd_d           = 1'b1;
          din_d            = req_data[int'(sel_idx)*DW +: DW];
          owner_d          = sel_idx;
          last_d           = sel_idx;
          busy_d           = 1'b1;
          cnt_d            = CW'(1);
          state_d          = ST_WAIT;
        end
      end
      ST_WAIT: begin
        busy_d = 1'b1;
        // A completion seen on the final count still counts as success.
        if (spi_done) begin
          cmpl_d[owner_q] = 1'b1;
          cnt_d           = '0;
          gcnt_d          = GW'(1);
          state_d         = ST_GAP;
        end else if (cnt_q == CW'(TIMEOUT)) begin
          timeout_err_d = 1'b1;
          cnt_d         = '0;
          gcnt_d        = GW'(1);
          state_d       = ST_GAP;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      ST_GAP: begin
        if (gcnt_q == GW'(GAP)) begin
          busy_d  = 1'b0;
          gcnt_d  = '0;
          state_d = ST_IDLE;
        end else begin
          busy_d = 1'b1;
          gcnt_d = gcnt_q + GW'(1);
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      grant_q       <= '0;
      cmpl_q        <= '0;
      timeout_err_q <= 1'b0;
      busy_q        <= 1'b0;
      owner_q       <= '0;
      last_q        <= OW'(NREQ - 1);
      newd_q        <= 1'b0;
      din_q         <= '0;
      cnt_q         <= '0;
      gcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      cmpl_q        <= cmpl_d;
      timeout_err_q <= timeout_err_d;
      busy_q        <= busy_d;
      owner_q       <= owner_d;
      last_q        <= last_d;
      newd_q        <= newd_d;
      din_q         <= din_d;
      cnt_q         <= cnt_d;
      gcnt_q        <= gcnt_d;
    end
  end

  assign grant       = grant_q;
  assign cmpl        = cmpl_q;
  assign timeout_err = timeout_err_q;
  assign busy        = busy_q;
  assign owner       = owner_q;
  assign newd        = newd_q;
  assign din         = din_q;

endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// Directed testbench for spi_xfer_arbiter (NREQ=4, DW=12, TIMEOUT=16, GAP=2).
// Inputs change and outputs are sampled 1ns after each rising edge.
module tb_spi_xfer_arbiter;

  localparam int NREQ    = 4;
  localparam int DW      = 12;
  localparam int TIMEOUT = 16;
  localparam int GAP     = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NREQ-1:0]   req = '0;
  logic [NREQ*DW-1:0] req_data = '0;
  logic [NREQ-1:0]   grant;
  logic [NREQ-1:0]   cmpl;
  logic              timeout_err;
  logic              busy;
  logic [1:0]        owner;
  logic              newd;
  logic [DW-1:0]     din;
  logic              spi_done = 1'b0;

  int vectors     = 0;
  int miscompares = 0;

  spi_xfer_arbiter #(
    .NREQ(NREQ), .DW(DW), .TIMEOUT(TIMEOUT), .GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .grant(grant), .cmpl(cmpl), .timeout_err(timeout_err), .busy(busy),
    .owner(owner), .newd(newd), .din(din), .spi_done(spi_done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
  endtask

  // Drives one spi_done pulse from inside WAIT and walks through the gap to IDLE.
  task automatic finish_xfer();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    for (int i = 0; i < GAP; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    vectors++;
    if ({grant, cmpl, timeout_err, busy, newd} !== 11'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_ctrl: got %b expected 0", {grant, cmpl, timeout_err, busy, newd});
    end
    vectors++;
    if (owner !== 2'd0 || din !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL reset_owner_din: got owner=%0d din=%h expected 0/000", owner, din);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_single();
    req_data[2*DW +: DW] = 12'hA5C;
    req = 4'b0100;
    tick();
    req = 4'b0000;
    vectors++;
    if (grant !== 4'b0100 || newd !== 1'b1 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL single_grant: got grant=%b newd=%b busy=%b expected 0100/1/1", grant, newd, busy);
    end
    vectors++;
    if (din !== 12'hA5C || owner !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL single_word: got din=%h owner=%0d expected A5C/2", din, owner);
    end
    tick();
    vectors++;
    if (newd !== 1'b0 || grant !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL single_strobe_len: got newd=%b grant=%b expected 0/0000", newd, grant);
    end
    for (int i = 0; i < 8; i++) tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    vectors++;
    if (cmpl !== 4'b0100 || busy !== 1'b1 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL single_cmpl: got cmpl=%b busy=%b tmo=%b expected 0100/1/0", cmpl, busy, timeout_err);
    end
    tick();
    vectors++;
    if (busy !== 1'b1 || cmpl !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL single_gap2: got busy=%b cmpl=%b expected 1/0000", busy, cmpl);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || din !== 12'hA5C || owner !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL single_idle: got busy=%b din=%h owner=%0d expected 0/A5C/2", busy, din, owner);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0] expOrder [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic       prevBusy;
    bit         seen;
    do_reset();
    for (int i = 0; i < NREQ; i++) req_data[i*DW +: DW] = 12'h1A0 + 12'(i);
    req = 4'b1111;
    prevBusy = busy;
    for (int n = 0; n < 5; n++) begin
      seen = 1'b0;
      for (int c = 0; c < 12 && !seen; c++) begin
        tick();
        if (newd) begin
          seen = 1'b1;
          vectors++;
          if (prevBusy !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL b2b_newd_busy[%0d]: got busy before newd=%b expected 0", n, prevBusy);
          end
        end
        prevBusy = busy;
      end
      vectors++;
      if (!seen) begin
        miscompares++;
        $display("[TB] FAIL b2b_timeout[%0d]: got no newd expected newd within 12 cycles", n);
      end else begin
        vectors++;
        if (grant !== (4'b0001 << expOrder[n]) || owner !== expOrder[n]) begin
          miscompares++;
          $display("[TB] FAIL b2b_grant[%0d]: got grant=%b owner=%0d expected owner %0d", n, grant, owner, expOrder[n]);
        end
        vectors++;
        if (din !== 12'h1A0 + 12'(expOrder[n])) begin
          miscompares++;
          $display("[TB] FAIL b2b_din[%0d]: got %h expected %h", n, din, 12'h1A0 + 12'(expOrder[n]));
        end
        for (int c = 0; c < 5; c++) tick();
        spi_done = 1'b1;
        tick();
        spi_done = 1'b0;
        vectors++;
        if (cmpl !== (4'b0001 << expOrder[n])) begin
          miscompares++;
          $display("[TB] FAIL b2b_cmpl[%0d]: got %b expected owner %0d", n, cmpl, expOrder[n]);
        end
        prevBusy = busy;
      end
    end
    req = 4'b0000;
    for (int c = 0; c < 4; c++) tick();
  endtask

  task automatic test_timeout();
    logic sawCmpl;
    do_reset();
    req_data[0 +: DW]  = 12'h0F1;
    req_data[DW +: DW] = 12'h0E2;
    req = 4'b0001;
    tick();
    req = 4'b0010;
    sawCmpl = 1'b0;
    for (int c = 0; c < 15; c++) begin
      tick();
      if (cmpl !== 4'b0000 || timeout_err !== 1'b0) sawCmpl = 1'b1;
    end
    vectors++;
    if (sawCmpl) begin
      miscompares++;
      $display("[TB] FAIL tmo_early: got early cmpl/timeout_err expected none before count 16");
    end
    tick();
    vectors++;
    if (timeout_err !== 1'b1 || cmpl !== 4'b0000 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL tmo_pulse: got tmo=%b cmpl=%b busy=%b expected 1/0000/1", timeout_err, cmpl, busy);
    end
    tick();
    vectors++;
    if (timeout_err !== 1'b0 || grant !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL tmo_len: got tmo=%b grant=%b expected 0/0000", timeout_err, grant);
    end
    tick();
    tick();
    vectors++;
    if (grant !== 4'b0010 || owner !== 2'd1 || din !== 12'h0E2) begin
      miscompares++;
      $display("[TB] FAIL tmo_next: got grant=%b owner=%0d din=%h expected 0010/1/0E2", grant, owner, din);
    end
    req = 4'b0000;
    finish_xfer();
    tick();
  endtask

  task automatic test_done_at_limit();
    req_data[0 +: DW] = 12'h3C3;
    req = 4'b0001;
    tick();
    req = 4'b0000;
    vectors++;
    if (grant !== 4'b0001 || din !== 12'h3C3) begin
      miscompares++;
      $display("[TB] FAIL limit_grant: got grant=%b din=%h expected 0001/3C3", grant, din);
    end
    for (int c = 0; c < 15; c++) tick();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    vectors++;
    if (cmpl !== 4'b0001 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL limit_done_wins: got cmpl=%b tmo=%b expected 0001/0", cmpl, timeout_err);
    end
    tick();
    vectors++;
    if (timeout_err !== 1'b0 || cmpl !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL limit_after: got tmo=%b cmpl=%b expected 0/0000", timeout_err, cmpl);
    end
    tick();
  endtask

  task automatic test_async_reset();
    do_reset();
    req_data[DW +: DW] = 12'h7B4;
    req = 4'b0010;
    tick();
    req = 4'b0000;
    vectors++;
    if (grant !== 4'b0010 || owner !== 2'd1 || din !== 12'h7B4) begin
      miscompares++;
      $display("[TB] FAIL ar_grant: got grant=%b owner=%0d din=%h expected 0010/1/7B4", grant, owner, din);
    end
    tick();
    #2;
    rst = 1'b1;
    #1;
    vectors++;
    if ({grant, cmpl, timeout_err, busy, newd} !== 11'd0 || owner !== 2'd0 || din !== 12'h000) begin
      miscompares++;
      $display("[TB] FAIL ar_async: got ctrl=%b owner=%0d din=%h expected all 0",
               {grant, cmpl, timeout_err, busy, newd}, owner, din);
    end
    req = 4'b0011;
    tick();
    rst = 1'b0;
    tick();
    vectors++;
    if (grant !== 4'b0001 || owner !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL ar_regrant: got grant=%b owner=%0d expected 0001/0", grant, owner);
    end
    req = 4'b0000;
    finish_xfer();
    tick();
  endtask

  task automatic test_spurious_done();
    spi_done = 1'b1;
    tick();
    spi_done = 1'b0;
    vectors++;
    if (cmpl !== 4'b0000 || busy !== 1'b0 || grant !== 4'b0000) begin
      miscompares++;
      $display("[TB] FAIL sp_idle: got cmpl=%b busy=%b grant=%b expected 0000/0/0000", cmpl, busy, grant);
    end
    req = 4'b1000;
    tick();
    req = 4'b0000;
    spi_done = 1'b1;
    tick();
    vectors++;
    if (cmpl !== 4'b1000) begin
      miscompares++;
      $display("[TB] FAIL sp_cmpl: got %b expected 1000", cmpl);
    end
    tick();
    spi_done = 1'b0;
    vectors++;
    if (cmpl !== 4'b0000 || busy !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL sp_gap: got cmpl=%b busy=%b expected 0000/1", cmpl, busy);
    end
    tick();
    vectors++;
    if (busy !== 1'b0 || cmpl !== 4'b0000 || timeout_err !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL sp_end: got busy=%b cmpl=%b tmo=%b expected 0/0000/0", busy, cmpl, timeout_err);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_done_at_limit();
    test_async_reset();
    test_spurious_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
